uart_tx_queue: RTL and testbench

Transmit-side byte queue between the MMIO mapper and `uart_controller`. It accepts single bytes or whole 32-bit words from the CPU and buffers them as bytes, least-significant byte first. It drains them one at a time into the controller's `in_send_data_en`/`in_data` pair, pacing on the controller's `tx_active`/`tx_done` status. This lets software write words and bursts without polling `tx_done` per byte.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_byte_ring.sv | 90 +++++++++
 rtl/uart_tx_queue.sv | 130 +++++++++++++
 tb/tb_uart_tx_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Purpose : Shared definitions for the UART transmit queue.
//           - UART_TX_Q_DEPTH : default byte capacity of uart_tx_queue
//           - UART_BYTE_LANES : byte lanes in one CPU word
//           - tx_q_state_t    : drain FSM state encoding
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_TX_Q_DEPTH = 16;
  localparam int UART_BYTE_LANES = 4;

  typedef enum logic [1:0] {
    TXQ_IDLE      = 2'd0,
    TXQ_WAIT_ACT  = 2'd1,
    TXQ_WAIT_DONE = 2'd2,
    TXQ_GAP       = 2'd3
  } tx_q_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_ring.sv
`default_nettype none
// ============================================================================
// Module  : uart_byte_ring
// Purpose : DEPTH x 8 circular byte store with a 1-or-4-byte write port and
//           a 1-byte read port. Occupancy is tracked here; acceptance policy
//           (room checks) belongs to the caller.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           i_wr_en        - write strobe (caller guarantees room)
//           i_wr_word      - 1: write all four lanes of i_wr_data, 0: lane 0
//           i_wr_data      - write data, lane 0 lands at the write pointer
//           i_rd_en        - pop the head byte (caller guarantees non-empty)
//           o_rd_data      - current head byte
//           o_count        - registered occupancy
//           o_full/o_empty - registered occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module uart_byte_ring
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_Q_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic             i_wr_word,
  input  logic [31:0]      i_wr_data,
  input  logic             i_rd_en,
  output logic [7:0]       o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic [CNT_W-1:0] w_wr_n;
  logic [CNT_W-1:0] w_rd_n;
  logic [CNT_W-1:0] w_count_nxt;
  logic [AW-1:0]    w_lane_idx [UART_BYTE_LANES];

  assign w_wr_n      = !i_wr_en  ? '0 :
                       i_wr_word ? CNT_W'(UART_BYTE_LANES) : CNT_W'(1);
  assign w_rd_n      = CNT_W'(i_rd_en);
  assign w_count_nxt = r_count + w_wr_n - w_rd_n;

  // Lane addresses wrap naturally because they are AW bits wide.
  for (genvar l = 0; l < UART_BYTE_LANES; l++) begin : g_lane
    assign w_lane_idx[l] = r_wr_ptr + AW'(l);
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < UART_BYTE_LANES; l++) begin
      if (i_wr_en && (l == 0 || i_wr_word)) begin
        r_mem[w_lane_idx[l]] <= i_wr_data[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      // Low AW bits of the advance give the modulo-DEPTH step (4 mod 4 = 0).
      r_wr_ptr <= r_wr_ptr + w_wr_n[AW-1:0];
      r_rd_ptr <= r_rd_ptr + AW'(i_rd_en);
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_queue
// Purpose : Transmit byte queue between the MMIO mapper and uart_controller.
//           Accepts single bytes or 32-bit words (LSB first), drains one byte
//           per UART frame, pacing on the controller's tx_active/tx_done.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           in_push            - CPU write strobe
//           in_data            - CPU write data
//           in_send_word       - 1: enqueue 4 bytes, 0: enqueue in_data[7:0]
//           in_clear_overflow  - clears out_overflow
//           out_level          - bytes queued
//           out_full/out_empty - occupancy flags
//           out_overflow       - sticky, a push was rejected
//           out_send_data_en   - one-cycle send strobe to the controller
//           out_tx_data        - byte carried by the last strobe
//           in_tx_active       - controller busy status
//           in_tx_done         - controller frame-complete pulse
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_Q_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_push,
  input  logic [31:0]      in_data,
  input  logic             in_send_word,
  input  logic             in_clear_overflow,
  output logic [CNT_W-1:0] out_level,
  output logic             out_full,
  output logic             out_empty,
  output logic             out_overflow,
  output logic             out_send_data_en,
  output logic [7:0]       out_tx_data,
  input  logic             in_tx_active,
  input  logic             in_tx_done
);

  tx_q_state_t      r_state;
  logic             r_overflow;
  logic             r_send_en;
  logic [7:0]       r_tx_data;

  logic [CNT_W-1:0] w_level;
  logic [CNT_W-1:0] w_need;
  logic [CNT_W-1:0] w_free;
  logic             w_accept;
  logic             w_reject;
  logic             w_pop;
  logic [7:0]       w_head;

  // Room is judged on the occupancy before any same-cycle pop, so a pop
  // never makes room for a push in the same cycle.
  assign w_need   = in_send_word ? CNT_W'(UART_BYTE_LANES) : CNT_W'(1);
  assign w_free   = CNT_W'(DEPTH) - w_level;
  assign w_accept = in_push && (w_free >= w_need);
  assign w_reject = in_push && !w_accept;
  assign w_pop    = (r_state == TXQ_IDLE) && (w_level != '0);

  uart_byte_ring #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_word (in_send_word),
    .i_wr_data (in_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_level),
    .o_full    (out_full),
    .o_empty   (out_empty)
  );

  // A rejected push outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_reject) begin
      r_overflow <= 1'b1;
    end else if (in_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TXQ_IDLE;
      r_send_en <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_send_en <= w_pop;
      if (w_pop) begin
        r_tx_data <= w_head;
      end
      case (r_state)
        TXQ_IDLE: begin
          if (w_pop) r_state <= TXQ_WAIT_ACT;
        end
        TXQ_WAIT_ACT: begin
          // A frame short enough to finish before tx_active is seen
          // goes straight to the cleanup gap.
          if (in_tx_active)    r_state <= TXQ_WAIT_DONE;
          else if (in_tx_done) r_state <= TXQ_GAP;
        end
        TXQ_WAIT_DONE: begin
          if (in_tx_done) r_state <= TXQ_GAP;
        end
        TXQ_GAP: begin
          r_state <= TXQ_IDLE;
        end
        default: begin
          r_state <= TXQ_IDLE;
        end
      endcase
    end
  end

  assign out_level        = w_level;
  assign out_overflow     = r_overflow;
  assign out_send_data_en = r_send_en;
  assign out_tx_data      = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_queue
// Purpose : Directed bench for uart_tx_queue (DEPTH = 16). A vector table
//           covers single-byte, word and overflow behaviour; short hand
//           sequences cover wrap-around with coincident push/pop and
//           asynchronous reset mid-frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_push;
  logic [31:0]      in_data;
  logic             in_send_word;
  logic             in_clear_overflow;
  logic [CNT_W-1:0] out_level;
  logic             out_full;
  logic             out_empty;
  logic             out_overflow;
  logic             out_send_data_en;
  logic [7:0]       out_tx_data;
  logic             in_tx_active;
  logic             in_tx_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        push;
    logic        word;
    logic [31:0] data;
    logic        clr;
    logic        act;
    logic        done;
    int          lvl;
    logic        ovf;
    logic        en;
    logic [7:0]  txd;
  } vec_t;

  vec_t tv [0:63];
  int   n_tv = 0;

  uart_tx_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_push           (in_push),
    .in_data           (in_data),
    .in_send_word      (in_send_word),
    .in_clear_overflow (in_clear_overflow),
    .out_level         (out_level),
    .out_full          (out_full),
    .out_empty         (out_empty),
    .out_overflow      (out_overflow),
    .out_send_data_en  (out_send_data_en),
    .out_tx_data       (out_tx_data),
    .in_tx_active      (in_tx_active),
    .in_tx_done        (in_tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int lvl, input logic ovf,
                          input logic en, input logic [7:0] txd);
    check({tag, ".level"}, 32'(out_level), 32'(lvl));
    check({tag, ".full"},  32'(out_full),  32'(lvl == DEPTH));
    check({tag, ".empty"}, 32'(out_empty), 32'(lvl == 0));
    check({tag, ".ovf"},   32'(out_overflow), 32'(ovf));
    check({tag, ".en"},    32'(out_send_data_en), 32'(en));
    check({tag, ".txd"},   32'(out_tx_data), 32'(txd));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_push = 1'b0; in_send_word = 1'b0; in_data = 32'h0;
    in_clear_overflow = 1'b0; in_tx_active = 1'b0; in_tx_done = 1'b0;
  endtask

  task automatic add(input logic push, input logic word, input logic [31:0] data,
                     input logic clr, input logic act, input logic done,
                     input int lvl, input logic ovf, input logic en, input logic [7:0] txd);
    tv[n_tv] = '{push, word, data, clr, act, done, lvl, ovf, en, txd};
    n_tv++;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      in_push = tv[i].push; in_send_word = tv[i].word; in_data = tv[i].data;
      in_clear_overflow = tv[i].clr; in_tx_active = tv[i].act; in_tx_done = tv[i].done;
      step();
      chk_outs($sformatf("vec%0d", i), tv[i].lvl, tv[i].ovf, tv[i].en, tv[i].txd);
    end
    idle_inputs();
  endtask

  task automatic push(input logic word, input logic [31:0] data);
    in_push = 1'b1; in_send_word = word; in_data = data;
  endtask

  // Finish the frame in flight with a tx_done pulse, then expect the next
  // strobe exactly two cycles later (GAP, IDLE) carrying exp_txd.
  task automatic drain_one(input logic [7:0] exp_txd, input int exp_lvl);
    bit seen = 1'b0;
    in_tx_done = 1'b1;
    step();
    in_tx_done = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      step();
      if (out_send_data_en) begin
        seen = 1'b1;
        check($sformatf("drain%0h.lat", exp_txd), 32'(c), 32'd2);
        check($sformatf("drain%0h.txd", exp_txd), 32'(out_tx_data), 32'(exp_txd));
        check($sformatf("drain%0h.lvl", exp_txd), 32'(out_level), 32'(exp_lvl));
      end
    end
    if (!seen) check($sformatf("drain%0h.timeout", exp_txd), 32'd0, 32'd1);
  endtask

  initial begin
    int t12_end;
    int t3_end;

    // ---- vector table -------------------------------------------------
    // Single byte 8'h41: level 0 -> 1 -> 0, one strobe, 10 active cycles.
    add(1, 0, 32'h41, 0, 0, 0, 1, 0, 0, 8'h00);
    add(0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 8'h41);
    for (int k = 0; k < 10; k++) add(0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 8'h41);
    add(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 8'h41);   // done -> GAP
    add(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h41);   // GAP -> IDLE
    add(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h41);   // empty: no strobe
    // Word 32'h44434241: strobes 41,42,43,44; level 4,3,2,1,0.
    add(1, 1, 32'h44434241, 0, 0, 0, 4, 0, 0, 8'h41);
    add(0, 0, 32'h0, 0, 0, 0, 3, 0, 1, 8'h41);
    add(0, 0, 32'h0, 0, 1, 0, 3, 0, 0, 8'h41);
    add(0, 0, 32'h0, 0, 0, 1, 3, 0, 0, 8'h41);
    add(0, 0, 32'h0, 0, 0, 0, 3, 0, 0, 8'h41);
    add(0, 0, 32'h0, 0, 0, 0, 2, 0, 1, 8'h42);
    add(0, 0, 32'h0, 0, 0, 1, 2, 0, 0, 8'h42);   // short frame: done only
    add(0, 0, 32'h0, 0, 0, 0, 2, 0, 0, 8'h42);
    add(0, 0, 32'h0, 0, 0, 0, 1, 0, 1, 8'h43);
    add(0, 0, 32'h0, 0, 1, 0, 1, 0, 0, 8'h43);
    add(0, 0, 32'h0, 0, 1, 0, 1, 0, 0, 8'h43);
    add(0, 0, 32'h0, 0, 0, 1, 1, 0, 0, 8'h43);
    add(0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 8'h43);
    add(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 8'h44);
    add(0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 8'h44);
    add(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 8'h44);
    add(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h44);
    add(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h44);
    t12_end = n_tv;
    // Fill to 14 with the FSM parked in WAIT_ACT, then overflow handling.
    add(1, 1, 32'hA3A2A1A0, 0, 0, 0, 4,  0, 0, 8'hDD);
    add(1, 1, 32'hB3B2B1B0, 0, 0, 0, 7,  0, 1, 8'hA0);   // push + pop
    add(1, 1, 32'hC3C2C1C0, 0, 0, 0, 11, 0, 0, 8'hA0);
    add(1, 0, 32'hD0,       0, 0, 0, 12, 0, 0, 8'hA0);
    add(1, 0, 32'hD1,       0, 0, 0, 13, 0, 0, 8'hA0);
    add(1, 0, 32'hD2,       0, 0, 0, 14, 0, 0, 8'hA0);
    add(1, 1, 32'hE3E2E1E0, 0, 0, 0, 14, 1, 0, 8'hA0);   // word rejected
    add(1, 0, 32'hD3,       0, 0, 0, 15, 1, 0, 8'hA0);   // byte fits
    add(0, 0, 32'h0,        1, 0, 0, 15, 0, 0, 8'hA0);   // clear
    add(1, 0, 32'hD4,       0, 0, 0, 16, 0, 0, 8'hA0);   // full
    add(1, 0, 32'hD5,       0, 0, 0, 16, 1, 0, 8'hA0);   // byte rejected
    add(1, 0, 32'hD6,       1, 0, 0, 16, 1, 0, 8'hA0);   // reject beats clear
    t3_end = n_tv;

    // ---- reset --------------------------------------------------------
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 8'h00);
    rst_n = 1'b1;

    run_vecs(0, t12_end);

    // ---- wrap-around with word push coincident with a pop at level 4 ----
    push(1, 32'h44332211); step(); chk_outs("w1", 4, 0, 0, 8'h44);
    push(1, 32'h88776655); step(); chk_outs("w2", 7, 0, 1, 8'h11);
    push(0, 32'h99);       step(); chk_outs("b99", 8, 0, 0, 8'h11);
    idle_inputs();
    drain_one(8'h22, 7);
    drain_one(8'h33, 6);
    drain_one(8'h44, 5);
    drain_one(8'h55, 4);
    in_tx_done = 1'b1; step(); in_tx_done = 1'b0;
    step();
    push(1, 32'hDDCCBBAA); step(); idle_inputs();
    chk_outs("coinc", 7, 0, 1, 8'h66);
    drain_one(8'h77, 6);
    drain_one(8'h88, 5);
    drain_one(8'h99, 4);
    drain_one(8'hAA, 3);
    drain_one(8'hBB, 2);
    drain_one(8'hCC, 1);
    drain_one(8'hDD, 0);
    in_tx_done = 1'b1; step(); in_tx_done = 1'b0;
    step();
    step(); chk_outs("wrap_end", 0, 0, 0, 8'hDD);

    run_vecs(t12_end, t3_end);

    // ---- async reset while full with overflow set ----------------------
    #3 rst_n = 1'b0;
    #1 chk_outs("rst_full", 0, 0, 0, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // ---- async reset mid-frame with 6 bytes queued ----------------------
    push(0, 32'h10);       step(); chk_outs("r5a", 1, 0, 0, 8'h00);
    push(1, 32'h14131211); step(); chk_outs("r5b", 4, 0, 1, 8'h10);
    push(0, 32'h15);       step();
    push(0, 32'h16);       step(); idle_inputs();
    in_tx_active = 1'b1;   step(); chk_outs("r5c", 6, 0, 0, 8'h10);
    step();
    #2 rst_n = 1'b0;
    #1 chk_outs("rst_mid", 0, 0, 0, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    in_tx_active = 1'b0;
    in_tx_done = 1'b1; step(); in_tx_done = 1'b0;
    chk_outs("stray_done", 0, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_outs($sformatf("post_rst%0d", k), 0, 0, 0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
